// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage.
// Holds the 10-bit PC, drives the synchronous instruction memory with the
// next-PC so that imem_data always corresponds to the current PC, applies
// jump/branch redirects ahead of stall/freeze, and stops fetching on HALT_WORD.
// Optional build macro: IF_STAGE_PERF_CNT_EN adds fetch_count/stall_count.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_RUN  | fetching normally; PC advances when enabled and not stalled
// ST_HALT | HALT_WORD retired; PC frozen, NOPs issued until a redirect
module if_stage #(
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        PC_write,
  input  logic        branch_taken,
  input  logic [9:0]  branch_addr,
  input  logic        jump_sel,
  input  logic [9:0]  jump_addr,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instruc_out,
  output logic [9:0]  PC_plus_1_out,
  output logic        halted
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      r_state;
  logic [9:0]  r_pc;

  logic        w_redirect;
  logic        w_is_halted;
  logic        w_halt_now;
  logic        w_advance;
  logic [9:0]  w_pc_plus_1;
  logic [9:0]  w_next_pc;

  assign w_redirect  = jump_sel | branch_taken;
  assign w_is_halted = (r_state == ST_HALT);
  assign w_pc_plus_1 = r_pc + 10'd1;

  // The halt word is recognised in the same cycle it is presented, so the PC
  // freezes on the halt address instead of running one word past it.
  assign w_halt_now = (imem_data == HALT_WORD) & enable & PC_write &
                      ~w_redirect & ~w_is_halted;

  assign w_advance = ~reset & ~w_redirect & ~w_is_halted & ~w_halt_now &
                     enable & PC_write;

  // Next-PC selection; redirects win over halt, freeze and stall.
  always_comb begin
    w_next_pc = r_pc;
    if (reset) begin
      w_next_pc = 10'd0;
    end else if (jump_sel) begin
      w_next_pc = jump_addr;
    end else if (branch_taken) begin
      w_next_pc = branch_addr;
    end else if (w_advance) begin
      w_next_pc = w_pc_plus_1;
    end
  end

  assign imem_addr     = w_next_pc;
  assign PC_plus_1_out = w_pc_plus_1;
  assign instruc_out   = w_is_halted ? 32'h0 : imem_data;
  assign halted        = w_is_halted;

  // PC register and run/halt state machine.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc    <= 10'd0;
      r_state <= ST_RUN;
    end else begin
      r_pc <= w_next_pc;
      case (r_state)
        ST_RUN: begin
          if (w_halt_now) begin
            r_state <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (w_redirect) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;
  logic        w_stall_cycle;

  assign w_stall_cycle = enable & ~PC_write & ~w_redirect & ~w_is_halted;

  // Saturating performance counters: sequential advances and stall cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_count <= 32'd0;
      r_stall_count <= 32'd0;
    end else begin
      if (w_advance && (r_fetch_count != 32'hFFFFFFFF)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_stall_cycle && (r_stall_count != 32'hFFFFFFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;
`endif

endmodule
